// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the register file and its read ports.
package cpu_pkg;
   localparam int REG_W      = 32;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DEPTH  = 2 ** REG_ADDR_W;
   localparam int WR_CNT_W   = 16;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_W-1:0]      word_t;

   localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_rd_port.sv
// One combinational register-file read port: 32:1 mux, address-0 force and,
// when REGFILE_WR_BYPASS_EN is defined, write-through forwarding from the write port.
module regfile_rd_port
   import cpu_pkg::*;
#(
   parameter int DATA_W = REG_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic [DATA_W-1:0] rf [2**ADDR_W],
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              fwd_we,
   input  logic [ADDR_W-1:0] wt_addr,
   input  logic [DATA_W-1:0] wt_data,
   output logic [DATA_W-1:0] rd_data
);

`ifdef REGFILE_WR_BYPASS_EN
   logic hit;
   assign hit = fwd_we && (wt_addr != '0) && (wt_addr == rd_addr);
`else
   logic unused_fwd;
   assign unused_fwd = ^{fwd_we, wt_addr, wt_data};
`endif

   always_comb begin
      rd_data = rf[rd_addr];
`ifdef REGFILE_WR_BYPASS_EN
      if (hit) rd_data = wt_data;
`endif
      // Register 0 is hard-wired, whatever the mux or forwarding say.
      if (rd_addr == '0) rd_data = '0;
   end

endmodule

// File: rtl/reg_file_32x32.sv
// MIPS 32x32 register file: one synchronous write port, three async read ports (a, b, dbg).
// Optional same-cycle write-through forwarding on all read ports: REGFILE_WR_BYPASS_EN.
module reg_file_32x32
   import cpu_pkg::*;
#(
   parameter int DATA_W = REG_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wt_addr,
   input  logic [DATA_W-1:0] wt_data,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic [15:0]       wr_count
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [1:DEPTH-1];
   logic [DATA_W-1:0] rf   [DEPTH];
   logic              wr_commit;
   logic              fwd_we;

   assign wr_commit = we && (wt_addr != ADDR_W'(REG_ZERO));
   // Forwarding is suppressed while reset is held so reads stay at zero.
   assign fwd_we    = we && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < DEPTH; i++) regs[i] <= '0;
         wr_count <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++) begin
            if (wr_commit && (wt_addr == ADDR_W'(i))) regs[i] <= wt_data;
         end
         if (wr_commit) wr_count <= wr_count + 16'd1;
      end
   end

   always_comb begin
      rf[0] = '0;
      for (int i = 1; i < DEPTH; i++) rf[i] = regs[i];
   end

   regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
      .rf      (rf),
      .rd_addr (rd_addr_a),
      .fwd_we  (fwd_we),
      .wt_addr (wt_addr),
      .wt_data (wt_data),
      .rd_data (rd_data_a)
   );

   regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
      .rf      (rf),
      .rd_addr (rd_addr_b),
      .fwd_we  (fwd_we),
      .wt_addr (wt_addr),
      .wt_data (wt_data),
      .rd_data (rd_data_b)
   );

   regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_dbg (
      .rf      (rf),
      .rd_addr (dbg_addr),
      .fwd_we  (fwd_we),
      .wt_addr (wt_addr),
      .wt_data (wt_data),
      .rd_data (dbg_data)
   );

endmodule
